// File: rtl/serial_parity_checker.sv
// Serial frame deserializer with parity check: DATA_W data bits (LSB first) plus one parity bit in,
// one word plus a parity-error flag out on a valid/ready port.
module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic              s_bit,
    input  logic              s_first,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_perr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              abort
);

    // Handshakes: a serial bit transfers when s_valid & s_ready on a rising edge; a word transfers
    // when m_valid & m_ready, and m_data/m_perr/m_valid stay frozen until that happens.

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic              acc;
    logic [DATA_W-1:0] sreg;

    logic              accept;
    logic              restart;
    logic              last_data;
    logic              wr_en;
    logic [CW-1:0]     wr_idx;

    assign s_ready   = (state != DONE);
    assign accept    = s_valid & s_ready;
    assign restart   = accept & s_first;
    assign last_data = (cnt == CW'(DATA_W - 1));
    assign wr_en     = restart | (accept & (state == DATA));
    assign wr_idx    = restart ? '0 : cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (restart) state_nxt = (DATA_W == 1) ? PARITY : DATA;
            end
            DATA: begin
                if (restart)                  state_nxt = (DATA_W == 1) ? PARITY : DATA;
                else if (accept && last_data) state_nxt = PARITY;
            end
            PARITY: begin
                if (restart)     state_nxt = (DATA_W == 1) ? PARITY : DATA;
                else if (accept) state_nxt = DONE;
            end
            DONE: begin
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= 1'b0;
            sreg    <= '0;
            m_data  <= '0;
            m_perr  <= 1'b0;
            m_valid <= 1'b0;
            abort   <= 1'b0;
        end else begin
            abort <= 1'b0;
            for (int i = 0; i < DATA_W; i++) begin
                if (wr_en && wr_idx == CW'(i)) sreg[i] <= s_bit;
            end
            if (restart) begin
                // A new frame start wins over whatever partial frame was being collected.
                acc   <= s_bit;
                cnt   <= CW'(1);
                abort <= (state == DATA) || (state == PARITY);
            end else if (accept && state == DATA) begin
                acc <= acc ^ s_bit;
                cnt <= cnt + CW'(1);
            end else if (accept && state == PARITY) begin
                m_data  <= sreg;
                m_perr  <= acc ^ s_bit ^ ODD_PARITY;
                m_valid <= 1'b1;
            end else if (state == DONE && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
